// File: rtl/ctrl_pipe_if.sv
// ID-stage fields in, registered control bundles and stall telemetry out.
// CTRL_UPPER_IMM_EN widens the bundle to 11 bits (lui, auipc).
interface ctrl_pipe_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
`ifdef CTRL_UPPER_IMM_EN
  localparam int CW = 11;
`else
  localparam int CW = 9;
`endif

  logic [6:0]        opcode_i;
  logic [REG_AW-1:0] rs1_i;
  logic [REG_AW-1:0] rs2_i;
  logic [REG_AW-1:0] rd_i;
  logic              flush_i;
  logic              halt_i;
  logic              stall_o;
  logic [CW-1:0]     ex_ctrl_o;
  logic [CW-1:0]     mem_ctrl_o;
  logic [CW-1:0]     wb_ctrl_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic [REG_AW-1:0] mem_rd_o;
  logic [REG_AW-1:0] wb_rd_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output opcode_i, rs1_i, rs2_i, rd_i, flush_i, halt_i,
    input  stall_o, ex_ctrl_o, mem_ctrl_o, wb_ctrl_o,
    input  ex_rd_o, mem_rd_o, wb_rd_o, stall_cnt_o
  );

  modport slave (
    input  opcode_i, rs1_i, rs2_i, rd_i, flush_i, halt_i,
    output stall_o, ex_ctrl_o, mem_ctrl_o, wb_ctrl_o,
    output ex_rd_o, mem_rd_o, wb_rd_o, stall_cnt_o
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Decodes ID opcode into a control bundle carried through ID/EX, EX/MEM, MEM/WB (CTRL_UPPER_IMM_EN adds lui/auipc).
// Latency: ex_* one edge after acceptance, mem_* two, wb_* three.
// Backpressure: stall_o (combinational) holds IF/ID on load-use; flush/halt override it with a bubble.
module ctrl_pipe #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  ctrl_pipe_if.slave bus
);
`ifdef CTRL_UPPER_IMM_EN
  localparam int CW = 11;
`else
  localparam int CW = 9;
`endif

  localparam int B_MEM_TO_REG = 0;
  localparam int B_MEM_WRITE  = 1;
  localparam int B_REG_WRITE  = 2;
  localparam int B_LOAD       = 3;
  localparam int B_STORE      = 4;
  localparam int B_IMMD       = 5;
  localparam int B_JAL        = 6;
  localparam int B_JALR       = 7;
  localparam int B_BRANCH     = 8;

  logic [CW-1:0]     dec_ctrl;
  logic              use_rs1;
  logic              use_rs2;
  logic [CW-1:0]     ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [CNT_W-1:0]  stall_cnt;
  logic              ex_hit, mem_hit, hazard, stall, kill;
  logic [CW-1:0]     id_ctrl;
  logic [REG_AW-1:0] id_rd;

  always_comb begin
    dec_ctrl = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (bus.opcode_i)
      7'b0110011: begin
        dec_ctrl[B_REG_WRITE] = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011: begin
        dec_ctrl[B_REG_WRITE] = 1'b1;
        dec_ctrl[B_IMMD]      = 1'b1;
        use_rs1 = 1'b1;
      end
      7'b0000011: begin
        dec_ctrl[B_MEM_TO_REG] = 1'b1;
        dec_ctrl[B_REG_WRITE]  = 1'b1;
        dec_ctrl[B_IMMD]       = 1'b1;
        dec_ctrl[B_LOAD]       = 1'b1;
        use_rs1 = 1'b1;
      end
      7'b0100011: begin
        dec_ctrl[B_MEM_WRITE] = 1'b1;
        dec_ctrl[B_STORE]     = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b1100011: begin
        dec_ctrl[B_BRANCH] = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b1101111: begin
        dec_ctrl[B_REG_WRITE] = 1'b1;
        dec_ctrl[B_JAL]       = 1'b1;
      end
      7'b1100111: begin
        dec_ctrl[B_REG_WRITE] = 1'b1;
        dec_ctrl[B_IMMD]      = 1'b1;
        dec_ctrl[B_JALR]      = 1'b1;
        use_rs1 = 1'b1;
      end
`ifdef CTRL_UPPER_IMM_EN
      // Upper-immediate forms read no source registers.
      7'b0110111: begin
        dec_ctrl[B_REG_WRITE] = 1'b1;
        dec_ctrl[B_IMMD]      = 1'b1;
        dec_ctrl[9]           = 1'b1;
      end
      7'b0010111: begin
        dec_ctrl[B_REG_WRITE] = 1'b1;
        dec_ctrl[B_IMMD]      = 1'b1;
        dec_ctrl[10]          = 1'b1;
      end
`endif
      default: dec_ctrl = '0;
    endcase
  end

  assign ex_hit = ex_ctrl[B_LOAD] && (ex_rd != '0) &&
                  ((use_rs1 && (ex_rd == bus.rs1_i)) || (use_rs2 && (ex_rd == bus.rs2_i)));
  // The MEM-stage load only matters when its data is still a stage away.
  assign mem_hit = (LOAD_LAT == 2) && mem_ctrl[B_LOAD] && (mem_rd != '0) &&
                   ((use_rs1 && (mem_rd == bus.rs1_i)) || (use_rs2 && (mem_rd == bus.rs2_i)));
  assign hazard = ex_hit || mem_hit;
  assign stall  = hazard && !bus.flush_i && !bus.halt_i;
  assign kill   = stall || bus.flush_i || bus.halt_i;

  assign id_ctrl = kill ? '0 : dec_ctrl;
  assign id_rd   = (kill || !dec_ctrl[B_REG_WRITE]) ? '0 : bus.rd_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ex_ctrl   <= '0;
      mem_ctrl  <= '0;
      wb_ctrl   <= '0;
      ex_rd     <= '0;
      mem_rd    <= '0;
      wb_rd     <= '0;
      stall_cnt <= '0;
    end else begin
      ex_ctrl  <= id_ctrl;
      ex_rd    <= id_rd;
      mem_ctrl <= ex_ctrl;
      mem_rd   <= ex_rd;
      wb_ctrl  <= mem_ctrl;
      wb_rd    <= mem_rd;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_o     = stall;
  assign bus.ex_ctrl_o   = ex_ctrl;
  assign bus.mem_ctrl_o  = mem_ctrl;
  assign bus.wb_ctrl_o   = wb_ctrl;
  assign bus.ex_rd_o     = ex_rd;
  assign bus.mem_rd_o    = mem_rd;
  assign bus.wb_rd_o     = wb_rd;
  assign bus.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two instances (LOAD_LAT=1 with 2-bit counter, LOAD_LAT=2 with 16-bit counter)
// share stimulus and are compared against an instruction-history reference model.
`timescale 1ns/1ps
module tb_ctrl_pipe;
`ifdef CTRL_UPPER_IMM_EN
  localparam int CW = 11;
`else
  localparam int CW = 9;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [4:0]    rd;
  } st_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       flush = 1'b0, halt = 1'b0;

  int checks = 0;
  int failures = 0;

  st_t         ha[3], hb[3];
  int unsigned ca, cb;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.REG_AW(5), .CNT_W(2))  ifa ();
  ctrl_pipe_if #(.REG_AW(5), .CNT_W(16)) ifb ();

  assign ifa.opcode_i = opcode;
  assign ifa.rs1_i    = rs1;
  assign ifa.rs2_i    = rs2;
  assign ifa.rd_i     = rd;
  assign ifa.flush_i  = flush;
  assign ifa.halt_i   = halt;
  assign ifb.opcode_i = opcode;
  assign ifb.rs1_i    = rs1;
  assign ifb.rs2_i    = rs2;
  assign ifb.rd_i     = rd;
  assign ifb.flush_i  = flush;
  assign ifb.halt_i   = halt;

  ctrl_pipe #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2))  dut_a (.clk_i(clk), .reset_n_i(rst_n), .bus(ifa));
  ctrl_pipe #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) dut_b (.clk_i(clk), .reset_n_i(rst_n), .bus(ifb));

  // Bundle values per instruction class, written as hex from the bit list.
  function automatic logic [CW-1:0] dec(input logic [6:0] op);
    logic [31:0] v;
    case (op)
      OP_R:    v = 32'h004;
      OP_I:    v = 32'h024;
      OP_LD:   v = 32'h02D;
      OP_ST:   v = 32'h012;
      OP_BR:   v = 32'h100;
      OP_JAL:  v = 32'h044;
      OP_JALR: v = 32'h0A4;
`ifdef CTRL_UPPER_IMM_EN
      OP_LUI:  v = 32'h224;
      OP_AUI:  v = 32'h424;
`endif
      default: v = 32'h000;
    endcase
    return v[CW-1:0];
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_ST, OP_BR};
  endfunction

  function automatic bit is_load_to(input st_t s, input logic [4:0] r);
    return (s.c == dec(OP_LD)) && (s.rd != 0) && (s.rd == r);
  endfunction

  function automatic bit conflicts(input st_t s);
    return (reads_rs1(opcode) && is_load_to(s, rs1)) || (reads_rs2(opcode) && is_load_to(s, rs2));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    check("a_ex_ctrl",  32'(ifa.ex_ctrl_o),   32'(ha[0].c));
    check("a_ex_rd",    32'(ifa.ex_rd_o),     32'(ha[0].rd));
    check("a_mem_ctrl", 32'(ifa.mem_ctrl_o),  32'(ha[1].c));
    check("a_mem_rd",   32'(ifa.mem_rd_o),    32'(ha[1].rd));
    check("a_wb_ctrl",  32'(ifa.wb_ctrl_o),   32'(ha[2].c));
    check("a_wb_rd",    32'(ifa.wb_rd_o),     32'(ha[2].rd));
    check("a_cnt",      32'(ifa.stall_cnt_o), ca);
    check("b_ex_ctrl",  32'(ifb.ex_ctrl_o),   32'(hb[0].c));
    check("b_ex_rd",    32'(ifb.ex_rd_o),     32'(hb[0].rd));
    check("b_mem_ctrl", 32'(ifb.mem_ctrl_o),  32'(hb[1].c));
    check("b_mem_rd",   32'(ifb.mem_rd_o),    32'(hb[1].rd));
    check("b_wb_ctrl",  32'(ifb.wb_ctrl_o),   32'(hb[2].c));
    check("b_wb_rd",    32'(ifb.wb_rd_o),     32'(hb[2].rd));
    check("b_cnt",      32'(ifb.stall_cnt_o), cb);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      ha[i] = '0;
      hb[i] = '0;
    end
    ca = 0;
    cb = 0;
    check_outs();
    check("a_stall_rst", 32'(ifa.stall_o), 0);
    check("b_stall_rst", 32'(ifb.stall_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input logic fl, input logic ht);
    opcode = op; rs1 = r1; rs2 = r2; rd = d; flush = fl; halt = ht;
  endtask

  // One clock: check the combinational stall, take the edge, then check registered state.
  task automatic cycle();
    bit sa, sb;
    st_t na, nb, acc;
    #1;
    sa = conflicts(ha[0]) && !flush && !halt;
    sb = (conflicts(hb[0]) || conflicts(hb[1])) && !flush && !halt;
    check("a_stall", 32'(ifa.stall_o), 32'(sa));
    check("b_stall", 32'(ifb.stall_o), 32'(sb));
    acc.c  = dec(opcode);
    acc.rd = (dec(opcode) == '0 || !reads_writes(opcode)) ? 5'd0 : rd;
    na = (sa || flush || halt) ? st_t'(0) : acc;
    nb = (sb || flush || halt) ? st_t'(0) : acc;
    @(posedge clk);
    #1;
    ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = na;
    hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = nb;
    if (sa && ca < 3) ca++;
    if (sb && cb < 65535) cb++;
    check_outs();
    @(negedge clk);
  endtask

  function automatic bit reads_writes(input logic [6:0] op);
`ifdef CTRL_UPPER_IMM_EN
    return op inside {OP_R, OP_I, OP_LD, OP_JAL, OP_JALR, OP_LUI, OP_AUI};
`else
    return op inside {OP_R, OP_I, OP_LD, OP_JAL, OP_JALR};
`endif
  endfunction

  logic [6:0] ops [10];

  initial begin
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUI, 7'b1111111};
    @(negedge clk);
    drive(OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    do_reset();

    // R-type flows through all three stages.
    drive(OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    cycle();
    check("r_ex_ctrl", 32'(ifa.ex_ctrl_o), 32'h004);
    check("r_ex_rd",   32'(ifa.ex_rd_o),   32'd3);
    drive(7'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle();
    cycle();
    check("r_wb_ctrl", 32'(ifb.wb_ctrl_o), 32'h004);

    // Load-use on rs2, consumer held for three cycles.
    do_reset();
    drive(OP_LD, 5'd9, 5'd0, 5'd5, 1'b0, 1'b0);
    cycle();
    drive(OP_R, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0);
    cycle();
    check("lu_bubble_a", 32'(ifa.ex_ctrl_o), 32'h000);
    cycle();
    cycle();
    check("lu_cnt_a", 32'(ifa.stall_cnt_o), 32'd1);
    check("lu_cnt_b", 32'(ifb.stall_cnt_o), 32'd2);

    // No false hazards: rd=0 load, and JAL after load.
    drive(OP_LD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle();
    drive(OP_R, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
    cycle();
    drive(OP_LD, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
    cycle();
    drive(OP_JAL, 5'd7, 5'd7, 5'd1, 1'b0, 1'b0);
    cycle();

    // Flush and halt win over a live hazard.
    drive(OP_LD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    cycle();
    drive(OP_R, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    cycle();
    check("flush_ex", 32'(ifa.ex_ctrl_o), 32'h000);
    drive(OP_LD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    cycle();
    drive(OP_ST, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1);
    cycle();
    check("halt_cnt_a", 32'(ifa.stall_cnt_o), 32'd1);

    // Saturation of the 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(OP_LD, 5'd2, 5'd0, 5'd1, 1'b0, 1'b0);
      cycle();
      drive(OP_BR, 5'd1, 5'd3, 5'd0, 1'b0, 1'b0);
      cycle();
      cycle();
    end
    check("sat_cnt_a", 32'(ifa.stall_cnt_o), 32'd3);

    // Upper-immediate decode, feature-dependent.
    drive(OP_LUI, 5'd1, 5'd1, 5'd2, 1'b0, 1'b0);
    cycle();
`ifdef CTRL_UPPER_IMM_EN
    check("lui_ctrl", 32'(ifa.ex_ctrl_o), 32'h224);
    check("lui_rd",   32'(ifa.ex_rd_o),   32'd2);
`else
    check("lui_ctrl", 32'(ifa.ex_ctrl_o), 32'h000);
    check("lui_rd",   32'(ifa.ex_rd_o),   32'd0);
`endif

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      drive(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised pipelined control unit for the in-order RISC-V core. It decodes the ID-stage opcode into a control bundle and carries that bundle through registered ID/EX, EX/MEM and MEM/WB stages. It detects load-use hazards with a configurable memory load latency, injecting bubbles on stall, flush or halt. A saturating stall counter is exported for performance monitoring.

## Interface
Parameters:
- REG_AW, 5: register address width.
- LOAD_LAT, 1: load data latency in stages beyond EX; legal values 1 or 2.
- CNT_W, 16: stall counter width.

Ports:
- clk_i  in  1  core clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- opcode_i  in  7  ID-stage instruction opcode.
- rs1_i, rs2_i, rd_i  in  REG_AW each  ID-stage register fields.
- flush_i  in  1  kill the ID-stage instruction (taken branch or jump).
- halt_i  in  1  decode as NOP (write-back flush-flop equivalent).
- stall_o  out  1  hold PC and IF/ID this cycle (combinational).
- ex_ctrl_o, mem_ctrl_o, wb_ctrl_o  out  CW each  registered control bundles.
- ex_rd_o, mem_rd_o, wb_rd_o  out  REG_AW each  registered destination registers.
- stall_cnt_o  out  CW_CNT=CNT_W  saturating count of stall cycles.

## Operation
- Bundle bit order, LSB first: mem_to_reg, mem_write, reg_write, load, store, immd, jal, jalr, branch. CW=9, or 11 with the upper-immediate feature, adding lui at bit 9 and auipc at bit 10.
- Decode, with all bits not listed at 0 and no X outputs anywhere:
  - 0110011 (R-type): reg_write.
  - 0010011 (I-type arithmetic): reg_write, immd.
  - 0000011 (load): mem_to_reg, reg_write, immd, load.
  - 0100011 (store): mem_write, store.
  - 1100011 (branch): branch.
  - 1101111 (JAL): reg_write, jal.
  - 1100111 (JALR): reg_write, immd, jalr.
  - Any other opcode: bubble, all zeros.
- Source-register usage:
  - rs1 is used by R-type, I-type arithmetic, load, store, branch and JALR.
  - rs2 is used by R-type, store and branch.
- Hazard condition: some stage S holds load=1 with rd≠0, and rd equals a used rs of the ID instruction.
  - S is EX.
  - S is also MEM when LOAD_LAT=2.
- stall_o = hazard & ~flush_i & ~halt_i.
- ID/EX input selection:
  - Bubble (ctrl=0, rd=0) if stall_o, flush_i or halt_i is asserted.
  - Otherwise the decoded bundle and rd_i. If the decoded bundle has reg_write=0, rd is forced to 0.
- EX/MEM and MEM/WB always advance; they are never stalled.
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at 2^CNT_W−1.

## Timing
- Reset, asynchronous, while reset_n_i=0:
  - All ctrl and rd outputs are 0.
  - stall_cnt_o is 0.
  - stall_o is 0, because all pipeline registers hold zero.
- Latency: an ID instruction accepted at edge N appears on ex_* after N, on mem_* after N+1, and on wb_* after N+2.
- A load-use hazard with LOAD_LAT=1 stalls exactly 1 cycle. With LOAD_LAT=2 it stalls 2 cycles, because the second stall comes from the MEM-stage match.
- flush_i and hazard in the same cycle: flush wins, stall_o=0, and a bubble enters EX.
- halt_i behaves identically to flush_i for the pipeline. halt_i does not count as a stall.
- rd=0 never causes a hazard.
- Reset deasserted mid-stream: the first edge after release loads a normal decode.

## Configuration
- CTRL_UPPER_IMM_EN:
  - Defined: CW=11.
    - 0110111 (LUI) decodes to reg_write, immd, lui.
    - 0010111 (AUIPC) decodes to reg_write, immd, auipc.
    - Neither instruction uses rs1 or rs2.
  - Undefined: CW=9, and both opcodes decode as bubbles.

## Test plan
- Reset: hold reset_n_i=0, drive opcode 0110011 → all outputs 0. Release, apply R-type with rd=3 → ex_ctrl_o=0x004 and ex_rd_o=3 after 1 edge; wb_ctrl_o=0x004 after 3 edges.
- Load-use, LOAD_LAT=1: load with rd=5, then add with rs2=5 → stall_o=1 for 1 cycle, ex_ctrl_o=0 for the bubble, stall_cnt_o=1. Repeat with LOAD_LAT=2 → 2 stall cycles, stall_cnt_o=2.
- No false hazard: load rd=0, then add rs1=0 → stall_o=0. Load rd=7, then JAL → stall_o=0, since JAL has no source registers.
- Flush priority: hazard present and flush_i=1 in the same cycle → stall_o=0, ex_ctrl_o=0 next cycle, counter unchanged.
- Saturation, CNT_W=2: force 5 stall cycles → stall_cnt_o sticks at 3.
- Macro: with CTRL_UPPER_IMM_EN defined, LUI rd=2 → ex_ctrl_o=0x224 (reg_write, immd, lui). Without the macro, LUI → ex_ctrl_o=0 and ex_rd_o=0.
